rf_wb_arbiter: RTL

- Shares the register file's single write port between two sources:
  - the pipeline writeback stage (WB);
  - the multi-cycle multiply/divide unit (MDU).
- Buffers MDU results in a small FIFO.
- Tracks registers with MDU results still outstanding, so the hazard unit can stall readers.
- Sits between WB/MDU and the register file's `we`/`addr_w`/`data_w` inputs.

---
 rtl/rf_wb_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter between pipeline writeback and a buffered MDU result FIFO,
// with a pending-write scoreboard. Define RF_ARB_STARVE_GUARD_EN to build the FIFO starvation guard.
module rf_wb_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        wb_stall,
    input  logic        md_valid,
    input  logic [4:0]  md_addr,
    input  logic [31:0] md_data,
    output logic        md_ready,
    input  logic        md_issue,
    input  logic [4:0]  md_issue_addr,
    output logic        md_issue_ok,
    input  logic [4:0]  hz_addr1,
    input  logic [4:0]  hz_addr2,
    output logic        hz_stall,
    output logic        rf_we,
    output logic [4:0]  rf_addr_w,
    output logic [31:0] rf_data_w
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pending_q, pending_d;
    logic [4:0]    fifo_addr_q [FIFO_DEPTH];
    logic [31:0]   fifo_data_q [FIFO_DEPTH];

    logic        fifo_empty, fifo_full, enq, head_grant, wb_grant, guard_fire, issue_ok;
    logic [4:0]  head_addr;
    logic [31:0] head_data;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign head_addr  = fifo_addr_q[rd_ptr_q];
    assign head_data  = fifo_data_q[rd_ptr_q];
    assign enq        = md_valid && !fifo_full;
    assign issue_ok   = md_issue && (md_issue_addr != 5'd0) && !pending_q[md_issue_addr];

`ifdef RF_ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt_q, starve_cnt_d;

    assign guard_fire = !fifo_empty && (starve_cnt_q == 4'(MAX_WAIT));

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (fifo_empty || head_grant)
            starve_cnt_d = 4'd0;
        else if (starve_cnt_q != 4'(MAX_WAIT))
            starve_cnt_d = starve_cnt_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) starve_cnt_q <= 4'd0;
        else      starve_cnt_q <= starve_cnt_d;
    end
`else
    logic unused_max_wait;
    assign unused_max_wait = ^MAX_WAIT;
    assign guard_fire      = 1'b0;
`endif

    // WB wins unless the guard fires; the head is only ever granted when WB is idle or stalled.
    assign head_grant = !fifo_empty && (!wb_we || guard_fire);
    assign wb_grant   = wb_we && !guard_fire;

    always_comb begin
        rf_addr_w = wb_addr;
        rf_data_w = wb_data;
        if (!wb_grant) begin
            rf_addr_w = head_addr;
            rf_data_w = head_data;
        end
    end

    assign rf_we       = rst && ((wb_grant && (wb_addr != 5'd0)) ||
                                 (head_grant && (head_addr != 5'd0)));
    assign wb_stall    = rst && guard_fire && wb_we;
    assign md_ready    = rst && !fifo_full;
    assign md_issue_ok = rst && issue_ok;
    assign hz_stall    = rst && (pending_q[hz_addr1] | pending_q[hz_addr2]);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pending_d = pending_q;
        count_d   = count_q + CW'(enq) - CW'(head_grant);
        if (enq)
            wr_ptr_d = wr_ptr_q + 1'b1;
        if (head_grant) begin
            rd_ptr_d             = rd_ptr_q + 1'b1;
            pending_d[head_addr] = 1'b0;
        end
        if (issue_ok)
            pending_d[md_issue_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pending_q <= '0;
        end else begin
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pending_q <= pending_d;
        end
    end

    // Payload storage carries no reset; occupancy is governed by count_q alone.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_addr_q[wr_ptr_q] <= md_addr;
            fifo_data_q[wr_ptr_q] <= md_data;
        end
    end
endmodule
